any_ffd_mc: RTL and testbench

//  Multi-channel NCO fractional clock divider. CH independent phase accumulators share one HF clock and

---
 rtl/any_ffd_mc.sv | 120 ++++++++++++
 tb/tb_any_ffd_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/any_ffd_mc.sv
// Multi-channel NCO fractional clock divider: every output is registered, one HF_Ck edge after its inputs.
// There is no backpressure; HF_CE freezes all accumulators and outputs, and config writes land on every edge.
module any_ffd_mc #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned NW    = 24,
  parameter logic [DW:0] NCO_D = {1'b1, {DW{1'b0}}},
  localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             HF_Ck,
  input  logic             Rs,
  input  logic             HF_CE,
  input  logic             Cfg_WE,
  input  logic [CW-1:0]    Cfg_Ch,
  input  logic [1:0]       Cfg_Sel,
  input  logic [DW-1:0]    Cfg_D,
  input  logic             Sync,
  output logic [CH*DW-1:0] Acc_O,
  output logic [CH-1:0]    LF_Ck_O,
  output logic [CH-1:0]    LF_CE_O,
  output logic [CH-1:0]    Wrap_O
);

  localparam logic [DW:0] HALF = NCO_D >> 1;
  localparam logic [DW:0] LIM  = NCO_D - 1'b1;

  logic [DW-1:0] acc    [CH];
  logic [DW-1:0] phase  [CH];
  logic [NW-1:0] n_act  [CH];
  logic [NW-1:0] n_sh   [CH];
  logic [CH-1:0] en;
  logic [CH-1:0] lf_ck;
  logic [CH-1:0] lf_ce;
  logic [CH-1:0] wrap;

  logic [NW-1:0] n_wr;
  logic [DW-1:0] ph_wr;
  logic [DW:0]   sum     [CH];
  logic [DW-1:0] acc_nxt [CH];
  logic [CH-1:0] wrap_c;
  logic [CH-1:0] hit;
  logic [CH-1:0] off;

  // Written values at or above the modulus saturate to the largest legal value.
  always_comb begin
    n_wr  = Cfg_D[NW-1:0];
    ph_wr = Cfg_D;
    if ({{(DW+1-NW){1'b0}}, Cfg_D[NW-1:0]} >= NCO_D) n_wr = LIM[NW-1:0];
    if ({1'b0, Cfg_D} >= NCO_D) ph_wr = LIM[DW-1:0];
  end

  // A ctrl write clearing enable takes effect on the same edge the write lands.
  always_comb begin
    hit    = '0;
    off    = '0;
    wrap_c = '0;
    for (int k = 0; k < CH; k++) begin
      hit[k]     = Cfg_WE && (Cfg_Ch == CW'(k));
      off[k]     = !en[k] || (hit[k] && (Cfg_Sel == 2'd2) && !Cfg_D[0]);
      sum[k]     = {1'b0, acc[k]} + {{(DW+1-NW){1'b0}}, n_act[k]};
      wrap_c[k]  = (sum[k] >= NCO_D);
      acc_nxt[k] = wrap_c[k] ? DW'(sum[k] - NCO_D) : sum[k][DW-1:0];
    end
  end

  always_ff @(posedge HF_Ck) begin
    if (Rs) begin
      for (int k = 0; k < CH; k++) begin
        acc[k]   <= '0;
        phase[k] <= '0;
        n_act[k] <= '0;
        n_sh[k]  <= '0;
      end
      en    <= '0;
      lf_ck <= '0;
      lf_ce <= '0;
      wrap  <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (off[k]) begin
          acc[k]   <= phase[k];
          n_act[k] <= n_sh[k];
          lf_ck[k] <= 1'b0;
          lf_ce[k] <= 1'b0;
          wrap[k]  <= 1'b0;
        end else if (Sync) begin
          acc[k]   <= phase[k];
          n_act[k] <= n_sh[k];
          lf_ck[k] <= ({1'b0, phase[k]} >= HALF);
          lf_ce[k] <= 1'b0;
          wrap[k]  <= 1'b0;
        end else if (HF_CE) begin
          // Increment changes only on a wrap, so no LF period is ever cut short.
          acc[k]   <= acc_nxt[k];
          lf_ck[k] <= ({1'b0, acc[k]} >= HALF);
          lf_ce[k] <= wrap_c[k];
          wrap[k]  <= wrap_c[k];
          if (wrap_c[k]) n_act[k] <= n_sh[k];
        end
        if (hit[k]) begin
          case (Cfg_Sel)
            2'd0:    n_sh[k]  <= n_wr;
            2'd1:    phase[k] <= ph_wr;
            2'd2:    en[k]    <= Cfg_D[0];
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_acc
    assign Acc_O[g*DW +: DW] = acc[g];
  end

  assign LF_Ck_O = lf_ck;
  assign LF_CE_O = lf_ce;
  assign Wrap_O  = wrap;

endmodule

// File: tb/tb_any_ffd_mc.sv
// Bench for any_ffd_mc: CH=3 so channel select 3 is out of range, DW=NW=9 so N=300 is representable, modulus 256.
module tb_any_ffd_mc;

  localparam int CH = 3;
  localparam int DW = 9;
  localparam int MOD = 256;

  logic          clk;
  logic          rs;
  logic          hf_ce;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_sel;
  logic [DW-1:0] cfg_d;
  logic          sync;
  logic [CH*DW-1:0] acc_o;
  logic [CH-1:0] lf_ck_o;
  logic [CH-1:0] lf_ce_o;
  logic [CH-1:0] wrap_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_acc [CH];
  int m_ph  [CH];
  int m_n   [CH];
  int m_nsh [CH];
  int m_en  [CH];
  int m_ck  [CH];
  int m_ce  [CH];
  int m_wr  [CH];

  int t1_acc [5] = '{64, 128, 192, 0, 64};
  int t1_ck  [5] = '{0, 0, 1, 1, 0};
  int t1_ce  [5] = '{0, 0, 0, 1, 0};
  int t2_acc [8] = '{96, 192, 32, 128, 224, 64, 160, 0};
  int t3_acc [4] = '{192, 0, 32, 64};
  int t4_ck  [4] = '{0, 0, 1, 1};

  any_ffd_mc #(.CH(CH), .DW(DW), .NW(DW), .NCO_D(10'd256)) dut (
    .HF_Ck(clk), .Rs(rs), .HF_CE(hf_ce), .Cfg_WE(cfg_we), .Cfg_Ch(cfg_ch),
    .Cfg_Sel(cfg_sel), .Cfg_D(cfg_d), .Sync(sync), .Acc_O(acc_o),
    .LF_Ck_O(lf_ck_o), .LF_CE_O(lf_ce_o), .Wrap_O(wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dacc(input int k);
    return int'(acc_o[k*DW +: DW]);
  endfunction

  // Reference: each channel is a modulo-256 counter with a deferred increment.
  task automatic model_step();
    int  s;
    int  d;
    bit  hit;
    bit  dis;
    d = (int'(cfg_d) > MOD - 1) ? MOD - 1 : int'(cfg_d);
    for (int k = 0; k < CH; k++) begin
      if (rs) begin
        m_acc[k] = 0; m_ph[k] = 0; m_n[k] = 0; m_nsh[k] = 0;
        m_en[k] = 0; m_ck[k] = 0; m_ce[k] = 0; m_wr[k] = 0;
      end else begin
        hit = cfg_we && (int'(cfg_ch) == k);
        dis = (m_en[k] == 0) || (hit && cfg_sel == 2'd2 && cfg_d[0] == 1'b0);
        if (dis) begin
          m_acc[k] = m_ph[k]; m_n[k] = m_nsh[k];
          m_ck[k] = 0; m_ce[k] = 0; m_wr[k] = 0;
        end else if (sync) begin
          m_acc[k] = m_ph[k]; m_n[k] = m_nsh[k];
          m_ck[k] = (m_ph[k] >= MOD / 2); m_ce[k] = 0; m_wr[k] = 0;
        end else if (hf_ce) begin
          s = m_acc[k] + m_n[k];
          m_ck[k] = (m_acc[k] >= MOD / 2);
          m_wr[k] = (s >= MOD);
          m_ce[k] = m_wr[k];
          m_acc[k] = s % MOD;
          if (m_wr[k] != 0) m_n[k] = m_nsh[k];
        end
        if (hit) begin
          case (cfg_sel)
            2'd0: m_nsh[k] = d;
            2'd1: m_ph[k]  = d;
            2'd2: m_en[k]  = int'(cfg_d[0]);
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < CH; k++) begin
      check($sformatf("acc%0d", k), dacc(k), m_acc[k]);
      check($sformatf("lfck%0d", k), lf_ck_o[k], m_ck[k]);
      check($sformatf("lfce%0d", k), lf_ce_o[k], m_ce[k]);
      check($sformatf("wrap%0d", k), wrap_o[k], m_wr[k]);
    end
  endtask

  task automatic cfg(input int ch, input int sel, input int d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_d = DW'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sync_tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  initial begin
    int pulses;
    rs = 1'b1; hf_ce = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_d = '0; sync = 1'b0;
    tick();
    tick();
    rs = 1'b0;
    check("rst_acc", acc_o, 0);
    check("rst_lf", {lf_ck_o, lf_ce_o, wrap_o}, 0);

    // Basic N=64 on ch0
    cfg(0, 0, 64);
    cfg(0, 2, 1);
    sync_tick();
    check("t1_sync_acc", dacc(0), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_acc", dacc(0), t1_acc[i]);
      check("t1_ck", lf_ck_o[0], t1_ck[i]);
      check("t1_ce", lf_ce_o[0], t1_ce[i]);
    end

    // Fractional N=96 on ch1
    cfg(1, 0, 96);
    cfg(1, 2, 1);
    sync_tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_acc", dacc(1), t2_acc[i]);
    end

    // Shadowed N change applies only at the next wrap
    sync_tick();
    tick();
    check("t3_acc_pre", dacc(0), 64);
    cfg(0, 0, 32);
    check("t3_acc_wr", dacc(0), 128);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_acc", dacc(0), t3_acc[i]);
    end

    // 180 degree phase offset between ch0 and ch1
    cfg(0, 0, 64);
    cfg(0, 1, 0);
    cfg(1, 0, 64);
    cfg(1, 1, 128);
    sync_tick();
    check("t4_ck0_sync", lf_ck_o[0], 0);
    check("t4_ck1_sync", lf_ck_o[1], 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_ck0", lf_ck_o[0], t4_ck[i % 4]);
      check("t4_ck1", lf_ck_o[1], 1 - t4_ck[i % 4]);
    end

    // HF_CE gating: 8 advances over 16 HF cycles
    sync_tick();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      hf_ce = (i % 2 == 0);
      tick();
      if (hf_ce && lf_ce_o[0]) pulses++;
    end
    hf_ce = 1'b1;
    check("t5_acc", dacc(0), 0);
    check("t5_pulses", pulses, 2);

    // Clamp, N=0 hold, out-of-range channel
    cfg(0, 0, 300);
    cfg(2, 0, 0);
    cfg(2, 1, 10);
    cfg(2, 2, 1);
    cfg(3, 1, 77);
    sync_tick();
    check("n0_sync", dacc(2), 10);
    tick();
    check("clamp_acc1", dacc(0), 255);
    tick();
    check("clamp_acc2", dacc(0), 254);
    check("n0_hold", dacc(2), 10);

    // Reset with concurrent Sync and config write
    rs = 1'b1; sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_d = 9'd5;
    tick();
    rs = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    check("t6_acc", acc_o, 0);
    check("t6_lf", {lf_ck_o, lf_ce_o, wrap_o}, 0);
    cfg(0, 2, 1);
    sync_tick();
    tick();
    check("t6_discard", dacc(0), 0);

    // Randomised traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rs      = ($urandom_range(199) == 0);
      hf_ce   = ($urandom_range(3) != 0);
      sync    = ($urandom_range(39) == 0);
      cfg_we  = ($urandom_range(3) == 0);
      cfg_ch  = 2'($urandom_range(3));
      cfg_sel = 2'($urandom_range(3));
      cfg_d   = DW'($urandom_range(511));
      if (cfg_sel == 2'd2 && $urandom_range(3) != 0) cfg_d[0] = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
